// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and a one-register-per-cycle clear sweep.
// Reads and busy lookups are combinational; same-cycle writeback can be forwarded.
module regfile_scoreboard #(
   parameter  int XLEN     = 32,
   parameter  int NREGS    = 32,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic            i_rfs_clk,
   input  logic            i_rfs_rst,
   input  logic [AW-1:0]   i_rfs_A1,
   input  logic [AW-1:0]   i_rfs_A2,
   input  logic [AW-1:0]   i_rfs_A3,
   input  logic [XLEN-1:0] i_rfs_WD3,
   input  logic            i_rfs_WE3,
   input  logic            i_rfs_issue_en,
   input  logic [AW-1:0]   i_rfs_issue_rd,
   output logic [XLEN-1:0] o_rfs_RD1,
   output logic [XLEN-1:0] o_rfs_RD2,
   output logic            o_rfs_busy1,
   output logic            o_rfs_busy2,
   output logic            o_rfs_ready
);

   localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state_reg;
   logic              ready_reg;
   logic [AW-1:0]     cnt_reg;
   logic [XLEN-1:0]   mem_reg [NREGS];
   logic [NREGS-1:0]  busy_vec;

   logic clr_en, upd_en, wr_en, iss_en, byp1, byp2;

   // Out-of-range addresses and (optionally) x0 are never stored, busy, or visible.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_ff @(posedge i_rfs_clk) begin
      if (i_rfs_rst) begin
         state_reg <= INIT;
         cnt_reg   <= '0;
         ready_reg <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  state_reg <= RUN;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= RUN;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign clr_en = (state_reg == INIT) && !i_rfs_rst;
   assign upd_en = (state_reg == RUN) && !i_rfs_rst;
   assign wr_en  = upd_en && i_rfs_WE3 && addr_ok(i_rfs_A3);
   assign iss_en = upd_en && i_rfs_issue_en && addr_ok(i_rfs_issue_rd);

   // Single write port; the array is only ever cleared by the sweep, never by reset.
   always_ff @(posedge i_rfs_clk) begin
      if (clr_en)
         mem_reg[cnt_reg] <= '0;
      else if (wr_en)
         mem_reg[i_rfs_A3] <= i_rfs_WD3;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_busy
         logic bit_reg;
         // Issue beats writeback: a new producer keeps the register busy.
         always_ff @(posedge i_rfs_clk) begin
            if (clr_en && (cnt_reg == AW'(gi)))
               bit_reg <= 1'b0;
            else if (iss_en && (i_rfs_issue_rd == AW'(gi)))
               bit_reg <= 1'b1;
            else if (wr_en && (i_rfs_A3 == AW'(gi)))
               bit_reg <= 1'b0;
         end
         assign busy_vec[gi] = bit_reg;
      end
   endgenerate

   assign byp1 = (BYPASS != 0) && wr_en && (i_rfs_A3 == i_rfs_A1);
   assign byp2 = (BYPASS != 0) && wr_en && (i_rfs_A3 == i_rfs_A2);

   always_comb begin
      o_rfs_RD1   = '0;
      o_rfs_RD2   = '0;
      o_rfs_busy1 = 1'b0;
      o_rfs_busy2 = 1'b0;
      if (ready_reg && addr_ok(i_rfs_A1)) begin
         o_rfs_RD1   = byp1 ? i_rfs_WD3 : mem_reg[i_rfs_A1];
         o_rfs_busy1 = busy_vec[i_rfs_A1] && !byp1;
      end
      if (ready_reg && addr_ok(i_rfs_A2)) begin
         o_rfs_RD2   = byp2 ? i_rfs_WD3 : mem_reg[i_rfs_A2];
         o_rfs_busy2 = busy_vec[i_rfs_A2] && !byp2;
      end
   end

   assign o_rfs_ready = ready_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: the driver queues the expected outputs of each cycle, a negedge monitor compares them.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  a1, a2, a3, ird;
   logic [31:0] wd;
   logic        we, ie;
   logic [31:0] rd1, rd2;
   logic        b1, b2, rdy;

   int cyc = 0;
   int total = 0;
   int passed = 0;

   typedef struct {
      int          cyc;
      string       name;
      logic        rdy;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        b1;
      logic        b2;
   } exp_t;

   exp_t q[$];
   exp_t e;

   regfile_scoreboard dut (
      .i_rfs_clk      (clk),
      .i_rfs_rst      (rst),
      .i_rfs_A1       (a1),
      .i_rfs_A2       (a2),
      .i_rfs_A3       (a3),
      .i_rfs_WD3      (wd),
      .i_rfs_WE3      (we),
      .i_rfs_issue_en (ie),
      .i_rfs_issue_rd (ird),
      .o_rfs_RD1      (rd1),
      .o_rfs_RD2      (rd2),
      .o_rfs_busy1    (b1),
      .o_rfs_busy2    (b2),
      .o_rfs_ready    (rdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation stamped with the current cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         total++;
         if (rdy !== e.rdy || rd1 !== e.rd1 || rd2 !== e.rd2 || b1 !== e.b1 || b2 !== e.b2)
            $display("FAIL %s cyc=%0d got rdy=%b rd1=%h rd2=%h b1=%b b2=%b expected rdy=%b rd1=%h rd2=%h b1=%b b2=%b",
                     e.name, cyc, rdy, rd1, rd2, b1, b2, e.rdy, e.rd1, e.rd2, e.b1, e.b2);
         else begin
            passed++;
            $display("ok   %s cyc=%0d rdy=%b rd1=%h rd2=%h b1=%b b2=%b", e.name, cyc, rdy, rd1, rd2, b1, b2);
         end
      end
   end

   task automatic step(input string nm, input logic [4:0] x1, x2, x3, input logic [31:0] xwd,
                       input logic xwe, xie, input logic [4:0] xrd,
                       input logic erdy, input logic [31:0] e1, e2, input logic eb1, eb2);
      exp_t t;
      a1 = x1; a2 = x2; a3 = x3; wd = xwd; we = xwe; ie = xie; ird = xrd;
      t.cyc = cyc; t.name = nm; t.rdy = erdy;
      t.rd1 = e1; t.rd2 = e2; t.b1 = eb1; t.b2 = eb2;
      q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a1 = '0; a2 = '0; a3 = '0; wd = '0; we = 1'b0; ie = 1'b0; ird = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      // Sweep: ready low for 32 cycles, writes/issues ignored, outputs masked.
      for (int i = 0; i < 32; i++)
         step("init_sweep", 5'(i), 5'(31 - i), 5'(i), 32'hFFFF_FFFF, 1'b1, 1'b1, 5'(i),
              1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++)
         step("init_clear", 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

      step("wr_bypass", 5'd5, 5'd4, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0,
           1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      step("wr_read", 5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);

      step("x0_write", 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd0,
           1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      step("x0_after", 5'd0, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

      step("issue7", 5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7,
           1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      step("busy7_a", 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
      step("busy7_b", 5'd7, 5'd6, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
      step("wb7_bypass", 5'd7, 5'd5, 5'd7, 32'h1234_5678, 1'b1, 1'b0, 5'd0,
           1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0);
      step("wb7_after", 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
      step("wb7_stays", 5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0);

      step("collide9", 5'd9, 5'd7, 5'd9, 32'hA5A5_A5A5, 1'b1, 1'b1, 5'd9,
           1'b1, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0, 1'b0);
      step("collide9_after", 5'd9, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b1, 1'b0);

      step("issue3", 5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd3,
           1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      step("issue12", 5'd3, 5'd12, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12,
           1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
      step("busy3_12", 5'd3, 5'd12, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'h0, 32'h0, 1'b1, 1'b1);

      // One-cycle reset mid-RUN; outputs during that cycle still reflect RUN.
      rst = 1'b1;
      step("rst_cycle", 5'd9, 5'd3, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
           1'b1, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b1);
      rst = 1'b0;
      // Writes/issues aim at registers the sweep already cleared (or reg 0).
      for (int i = 0; i < 32; i++)
         step("resweep", 5'd9, 5'd5, (i == 0) ? 5'd0 : 5'(i - 1), 32'h5555_AAAA, 1'b1, 1'b1,
              (i == 0) ? 5'd0 : 5'(i - 1), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++)
         step("post_reset", 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

      @(negedge clk);
      total++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain pending=%0d required=0", q.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
